// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline controller.
//   Stop/NoStop levels, stall vector bit indices, the four stall vector
//   constants, ZeroWord, default ERET code / exception vector, FSM states.
package pipe_ctrl_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Stall vector bit positions, front of the pipe first.
  localparam int unsigned STALL_PC_B  = 0;
  localparam int unsigned STALL_IF_B  = 1;
  localparam int unsigned STALL_ID_B  = 2;
  localparam int unsigned STALL_EX_B  = 3;
  localparam int unsigned STALL_MEM_B = 4;
  localparam int unsigned STALL_WB_B  = 5;
  localparam int unsigned STALL_W     = STALL_WB_B + 1;

  // A requesting stage freezes itself and every stage upstream of it.
  function automatic logic [STALL_W-1:0] stall_upto(input int unsigned top);
    logic [STALL_W-1:0] v;
    v = {STALL_W{NoStop}};
    for (int unsigned b = STALL_PC_B; b < STALL_W; b++)
      if (b <= top) v[b] = Stop;
    return v;
  endfunction

  localparam logic [STALL_W-1:0] STALL_NONE = {STALL_W{NoStop}};
  localparam logic [STALL_W-1:0] STALL_ID   = stall_upto(STALL_ID_B);  // 000111
  localparam logic [STALL_W-1:0] STALL_EX   = stall_upto(STALL_EX_B);  // 001111
  localparam logic [STALL_W-1:0] STALL_MEM  = stall_upto(STALL_MEM_B); // 011111

  localparam logic [31:0] ZeroWord       = 32'h0000_0000;
  localparam logic [31:0] ERET_CODE_DEF  = 32'h0000_000e;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// pipe_ctrl_wdog: consecutive-stall watchdog.
//   clk, rst       : clock, synchronous active-high reset
//   stalling       : stall vector is non-zero this cycle
//   stall_timeout  : sticky flag, set on the edge run_len reaches STALL_MAX
module pipe_ctrl_wdog #(
  parameter int STALL_MAX = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic stalling,
  output logic stall_timeout
);

  localparam int RW = $clog2(STALL_MAX + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STALL_MAX);

  logic [RW-1:0] run_len_q, run_len_d;
  logic          timeout_q;

  // Saturating run length; any non-stalling cycle (incl. flush) restarts it.
  always_comb begin
    run_len_d = '0;
    if (stalling)
      run_len_d = (run_len_q == RUN_MAX) ? run_len_q : run_len_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_len_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_len_q <= run_len_d;
      if (run_len_d == RUN_MAX) timeout_q <= 1'b1;
    end
  end

  assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 5-stage MIPS core.
//   stallreq_id/ex/mem : stall requests (priority mem > ex > id)
//   exc_req, exc_type  : exception / ERET commit from MEM
//   cp0_epc            : ERET return target
//   stall[5:0]         : PC,IF,ID,EX,MEM,WB freeze (1 = Stop), combinational
//   flush, new_pc      : pipeline clear and redirect target, combinational
//   stall_timeout      : sticky consecutive-stall watchdog flag
//   stall_cnt/flush_cnt: perf counters, built only with PIPE_CTRL_PERF_CNT_EN
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF,
  parameter int          STALL_MAX  = 64,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             exc_req,
  input  logic [31:0]      exc_type,
  input  logic [31:0]      cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e state_q, state_d;
  logic   wdog_timeout;

  always_comb begin
    state_d = state_q;
    stall   = STALL_NONE;
    flush   = 1'b0;
    new_pc  = ZeroWord;
    unique case (state_q)
      ST_RUN, ST_STALL: begin
        if (exc_req) begin
          // Exception overrides every stall request.
          flush   = 1'b1;
          new_pc  = (exc_type == ERET_CODE) ? cp0_epc : EXC_VECTOR;
          state_d = ST_FLUSH;
        end else begin
          if (stallreq_mem)     stall = STALL_MEM;
          else if (stallreq_ex) stall = STALL_EX;
          else if (stallreq_id) stall = STALL_ID;
          state_d = (stallreq_mem | stallreq_ex | stallreq_id) ? ST_STALL : ST_RUN;
        end
      end
      ST_FLUSH: begin
        // ID hazard and exc_req come from bubbles just flushed; ignore them.
        if (stallreq_mem)     stall = STALL_MEM;
        else if (stallreq_ex) stall = STALL_EX;
        state_d = (stallreq_mem | stallreq_ex) ? ST_STALL : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      stall   = STALL_NONE;
      flush   = 1'b0;
      new_pc  = ZeroWord;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  pipe_ctrl_wdog #(.STALL_MAX(STALL_MAX)) u_wdog (
    .clk           (clk),
    .rst           (rst),
    .stalling      (|stall),
    .stall_timeout (wdog_timeout)
  );

  assign stall_timeout = wdog_timeout & ~rst;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (|stall) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush)  flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = rst ? '0 : stall_cnt_q;
  assign flush_cnt = rst ? '0 : flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem, exc_req;
  logic [31:0] exc_type, cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .exc_req(exc_req), .exc_type(exc_type), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_timeout(stall_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: behaviour as rules, not as a state machine.
  bit          m_after_flush = 0;  // previous cycle flushed
  int          m_run = 0;          // consecutive stall cycles, capped at 64
  bit          m_to = 0;
  logic [31:0] m_sc = 0, m_fc = 0;
  bit          perf_en;

  task automatic step(input bit r, input bit id, input bit ex, input bit mem,
                      input bit exc, input logic [31:0] ty, input logic [31:0] epc);
    logic [5:0]  e_stall;
    bit          e_flush;
    logic [31:0] e_pc;
    @(negedge clk);
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    exc_req = exc; exc_type = ty; cp0_epc = epc;
    #1;
    e_stall = 6'b0; e_flush = 0; e_pc = 32'h0;
    if (!r) begin
      if (exc && !m_after_flush) begin
        e_flush = 1;
        e_pc = (ty == 32'he) ? epc : 32'h20;
      end else if (mem)                  e_stall = 6'b011111;
      else if (ex)                       e_stall = 6'b001111;
      else if (id && !m_after_flush)     e_stall = 6'b000111;
    end
    chk("stall",   64'(stall),         64'(e_stall));
    chk("flush",   64'(flush),         64'(e_flush));
    chk("new_pc",  64'(new_pc),        64'(e_pc));
    chk("timeout", 64'(stall_timeout), 64'(r ? 1'b0 : m_to));
    chk("stall_cnt", 64'(stall_cnt), 64'(r ? 32'h0 : m_sc));
    chk("flush_cnt", 64'(flush_cnt), 64'(r ? 32'h0 : m_fc));
    @(posedge clk);
    if (r) begin
      m_after_flush = 0; m_run = 0; m_to = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_after_flush = e_flush;
      if (e_stall != 0) m_run = (m_run < 64) ? m_run + 1 : 64;
      else              m_run = 0;
      if (m_run == 64) m_to = 1;
      if (perf_en && e_stall != 0) m_sc = m_sc + 1;
      if (perf_en && e_flush)      m_fc = m_fc + 1;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
`ifdef PIPE_CTRL_PERF_CNT_EN
    perf_en = 1;
`else
    perf_en = 0;
`endif
    // Reset with every request asserted.
    step(1, 1, 1, 1, 1, 32'h8, 32'hdead_beef);
    step(1, 1, 1, 1, 1, 32'he, 32'hdead_beef);
    idle();

    // Priority ladder.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    idle();

    // Exception with mem stall, held into the FLUSH cycle.
    step(0, 0, 0, 1, 1, 32'h8, 32'h0);
    step(0, 1, 0, 0, 1, 32'h8, 32'h0);
    chk("flush_masked", 64'(flush), 64'(0));
    idle();

    // ERET.
    step(0, 0, 0, 0, 1, 32'he, 32'h0000_1234);
    chk("eret_pc", 64'(new_pc), 64'h1234);
    step(0, 0, 1, 0, 0, 0, 0);   // ex honoured during FLUSH
    idle();

    // Watchdog: 63 cycles does not trip, 64 does.
    repeat (63) step(0, 0, 1, 0, 0, 0, 0);
    idle();
    chk("wd63", 64'(stall_timeout), 64'(0));
    repeat (64) step(0, 0, 1, 0, 0, 0, 0);
    idle();
    chk("wd64", 64'(stall_timeout), 64'(1));
    repeat (3) idle();
    chk("wd_sticky", 64'(stall_timeout), 64'(1));

    // Reset mid-stall, then perf scenario: 10 stalls + 2 flushes.
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    idle();
    chk("wd_cleared", 64'(stall_timeout), 64'(0));
    repeat (10) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h4, 0);
    idle();
    step(0, 0, 0, 0, 1, 32'he, 32'h40);
    idle();
    chk("perf_stall", 64'(stall_cnt), 64'(perf_en ? 10 : 0));
    chk("perf_flush", 64'(flush_cnt), 64'(perf_en ? 2 : 0));

    // Reset mid-FLUSH.
    step(0, 0, 0, 0, 1, 32'h4, 0);
    step(1, 1, 0, 0, 1, 32'h4, 0);
    step(0, 1, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, id, ex, mem, exc;
      logic [31:0] ty;
      r   = ($urandom_range(0, 199) == 0);
      id  = ($urandom_range(0, 3) == 0);
      ex  = ($urandom_range(0, 4) == 0);
      mem = ($urandom_range(0, 5) == 0);
      exc = ($urandom_range(0, 9) == 0);
      ty  = ($urandom_range(0, 1) == 0) ? 32'he : 32'($urandom_range(0, 31));
      step(r, id, ex, mem, exc, ty, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core; it drives the stall[5:0] vector and the flush/new_pc pair into every pipeline register.
- Arbitrates stall requests from ID (load-use), EX (multi-cycle ops) and MEM (memory wait), plus the exception/ERET request from MEM.
- Holds a small FSM, a consecutive-stall watchdog and optional performance counters.

Parameters:
- EXC_VECTOR, 32'h0000_0020, new_pc for any non-ERET exception.
- ERET_CODE, 32'h0000_000e, exc_type value meaning ERET.
- STALL_MAX, 64, consecutive stall cycles that trip the watchdog.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; reset rst, synchronous, active-high.
- rst  in  1  synchronous active-high reset.
- stallreq_id  in  1  load-use hazard from ID.
- stallreq_ex  in  1  multi-cycle op busy in EX.
- stallreq_mem  in  1  memory access not complete.
- exc_req  in  1  MEM stage commits an exception or ERET.
- exc_type  in  32  exception code; ERET_CODE selects the ERET path.
- cp0_epc  in  32  EPC value from CP0.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
- flush  out  1  clear all pipeline registers at this edge.
- new_pc  out  32  PC target when flush=1.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cnt  out  CNT_W  cycles with stall!=0 (only with PERF_CNT_EN).
- flush_cnt  out  CNT_W  number of flushes (only with PERF_CNT_EN).

Behaviour:
- stall, flush and new_pc are combinational from the inputs and the current state, so they take effect at the same clock edge as the request. Zero latency is mandatory.
- Stall priority is mem > ex > id:
  - stallreq_mem -> 6'b011111
  - else stallreq_ex -> 6'b001111
  - else stallreq_id -> 6'b000111
  - else 6'b000000
- Exception handling:
  - exc_req=1 in RUN or STALL -> flush=1 and stall=0, overriding all stall requests.
  - new_pc = cp0_epc if exc_type==ERET_CODE, else EXC_VECTOR.
  - When flush=0, new_pc=0.
- FSM states RUN, STALL, FLUSH; reset state is RUN.
  - RUN: exc_req -> FLUSH; else any stall request -> STALL; else RUN.
  - STALL: exc_req -> FLUSH; else any stall request -> STALL; else RUN.
  - FLUSH: lasts exactly one cycle. exc_req and stallreq_id are masked (stale bubbles), so flush=0. stallreq_ex and stallreq_mem are still honoured. Next state is STALL if an unmasked request is present, else RUN.
- Watchdog:
  - Counter run_len counts consecutive cycles with stall!=0.
  - It clears on any cycle with stall==0 or flush=1, and saturates at STALL_MAX.
  - When run_len reaches STALL_MAX, stall_timeout sets to 1 on that edge and stays set until rst. Stalling continues normally.
- Simultaneous exc_req with any stall request: flush wins and stall=0.
- Reset:
  - stall=0, flush=0, new_pc=0, stall_timeout=0, run_len=0, counters=0, state RUN.
  - Reset mid-stall or mid-FLUSH returns to RUN on the next edge.
  - While rst=1, all outputs are forced to reset values regardless of requests.

Optional Feature:
- Macro PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - stall_cnt increments every cycle with stall!=0.
  - flush_cnt increments every cycle with flush=1.
  - Both wrap modulo 2^CNT_W and clear on rst.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are built.

Decomposition:
- Shared define file holds: Stop/NoStop, stall bit indices, the four stall vector constants, ZeroWord, ERET code, exception vector, and the FSM state encodings.
- One sub-module, pipe_ctrl_wdog, containing the run_len counter and the sticky stall_timeout flag; its inputs are clk, rst and stalling.

Test Plan:
- Reset: rst=1 for 2 cycles with all requests=1 -> stall=0, flush=0, new_pc=0; state RUN after release.
- Priority: stallreq_id=1 -> stall=000111; add stallreq_ex -> 001111; add stallreq_mem -> 011111, all in the same cycle.
- Exception: exc_req=1, exc_type=8 with stallreq_mem=1 -> flush=1, stall=0, new_pc=0x20. Hold exc_req the next cycle -> flush=0 (FLUSH masks it).
- ERET: exc_req=1, exc_type=0x0e, cp0_epc=0x0000_1234 -> flush=1, new_pc=0x0000_1234.
- Watchdog: hold stallreq_ex for 63 cycles -> stall_timeout=0. Release and re-stall for 64 cycles -> stall_timeout=1, and it stays 1 after release until rst.
- With PIPE_CTRL_PERF_CNT_EN: 10 stall cycles plus 2 flushes -> stall_cnt=10, flush_cnt=2. Without the macro, both read 0.
